// File: rtl/read_buffer_pkg.sv
// Shared defaults, width helpers and response disposition codes for the read response buffer.
package read_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_DEPTH           = 4;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    typedef enum logic [2:0] {
        RSP_NONE,
        RSP_UNEXPECTED,
        RSP_FLUSH,
        RSP_DISCARD,
        RSP_STORE
    } rsp_disp_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int outstanding_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/read_response_buffer.sv
// FIFO for read responses with in-flight tracking; clear flushes stored data and
// discards responses to reads issued before the clear.
module read_response_buffer
    import read_buffer_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int DEPTH           = DEFAULT_DEPTH,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                read_issue,
    output logic                                can_issue,
    input  logic [DATA_WIDTH-1:0]               read_data,
    input  logic                                read_data_valid,
    input  logic                                pop,
    output logic [DATA_WIDTH-1:0]               head_data,
    output logic [count_width(DEPTH)-1:0]       count,
    output logic                                empty,
    output logic                                full,
    output logic                                overflow,
    output logic                                unexpected
);

    localparam int CW = count_width(DEPTH);
    localparam int OW = outstanding_width(MAX_OUTSTANDING);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         discard;
    logic [OW-1:0]         outstanding_next;
    logic                  rsp_hit;
    logic                  do_push;
    logic                  do_pop;
    logic                  overflow_evt;
    rsp_disp_t             disp;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head_data = mem[head];
    assign can_issue = ((int'(count) + int'(outstanding)) < DEPTH) &&
                       (int'(outstanding) < MAX_OUTSTANDING);

    always_comb begin
        rsp_hit          = read_data_valid && (outstanding != '0);
        outstanding_next = outstanding + OW'(read_issue) - OW'(rsp_hit);
        disp             = RSP_NONE;
        if (read_data_valid) begin
            if (outstanding == '0)
                disp = RSP_UNEXPECTED;
            else if (clear)
                disp = RSP_FLUSH;
            else if (discard != '0)
                disp = RSP_DISCARD;
            else
                disp = RSP_STORE;
        end
        do_pop       = pop && !empty && !clear;
        do_push      = (disp == RSP_STORE) && (!full || do_pop);
        overflow_evt = (disp == RSP_STORE) && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            outstanding <= '0;
            discard     <= '0;
            overflow    <= 1'b0;
            unexpected  <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (clear) begin
                count   <= '0;
                head    <= '0;
                tail    <= '0;
                // Reads still in flight from the old epoch; a same-cycle issue is not among them.
                discard <= outstanding - OW'(rsp_hit);
            end else begin
                if (disp == RSP_DISCARD)
                    discard <= discard - 1'b1;
                if (do_push)
                    tail <= tail + 1'b1;
                if (do_pop)
                    head <= head + 1'b1;
                if (do_push && !do_pop)
                    count <= count + 1'b1;
                else if (!do_push && do_pop)
                    count <= count - 1'b1;
            end
            if (disp == RSP_UNEXPECTED)
                unexpected <= 1'b1;
            if (overflow_evt)
                overflow <= 1'b1;
        end
    end

    // Storage is not reset; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[tail] <= read_data;
    end

endmodule

// File: tb/tb_read_response_buffer.sv
// Directed scoreboard bench for read_response_buffer: default instance plus a DEPTH=8, 64-bit instance.
module tb_read_response_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_clear, a_issue, a_valid, a_pop;
    logic [31:0] a_data;
    logic        a_can_issue, a_empty, a_full, a_overflow, a_unexpected;
    logic [31:0] a_head;
    logic [2:0]  a_count;

    logic        b_reset, b_clear, b_issue, b_valid, b_pop;
    logic [63:0] b_data;
    logic        b_can_issue, b_empty, b_full, b_overflow, b_unexpected;
    logic [63:0] b_head;
    logic [3:0]  b_count;

    read_response_buffer dut_a (
        .clk(clk), .reset(a_reset), .clear(a_clear), .read_issue(a_issue),
        .can_issue(a_can_issue), .read_data(a_data), .read_data_valid(a_valid),
        .pop(a_pop), .head_data(a_head), .count(a_count), .empty(a_empty),
        .full(a_full), .overflow(a_overflow), .unexpected(a_unexpected)
    );

    read_response_buffer #(.DATA_WIDTH(64), .DEPTH(8), .MAX_OUTSTANDING(4)) dut_b (
        .clk(clk), .reset(b_reset), .clear(b_clear), .read_issue(b_issue),
        .can_issue(b_can_issue), .read_data(b_data), .read_data_valid(b_valid),
        .pop(b_pop), .head_data(b_head), .count(b_count), .empty(b_empty),
        .full(b_full), .overflow(b_overflow), .unexpected(b_unexpected)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] sb_a [$];
    logic [63:0] sb_b [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic iss, input logic vld, input logic [31:0] d,
                          input logic pp, input logic clr, input logic rst);
        a_issue = iss; a_valid = vld; a_data = d; a_pop = pp; a_clear = clr; a_reset = rst;
        @(posedge clk); #1;
        a_issue = 1'b0; a_valid = 1'b0; a_pop = 1'b0; a_clear = 1'b0; a_reset = 1'b0;
    endtask

    task automatic issue_a(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step_a(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resp_a(input logic [31:0] d, input logic stored);
        if (stored) sb_a.push_back(d);
        step_a(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_a(input string tag);
        logic [31:0] exp;
        exp = (sb_a.size() != 0) ? sb_a.pop_front() : 'x;
        check(tag, 64'(a_head), 64'(exp));
        step_a(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        a_issue = 0; a_valid = 0; a_pop = 0; a_clear = 0; a_data = '0; a_reset = 1;
        b_issue = 0; b_valid = 0; b_pop = 0; b_clear = 0; b_data = '0; b_reset = 1;
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        b_reset = 1'b0;

        check("rst_empty", 64'(a_empty), 64'd1);
        check("rst_full", 64'(a_full), 64'd0);
        check("rst_can_issue", 64'(a_can_issue), 64'd1);
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_flags", 64'({a_overflow, a_unexpected}), 64'd0);

        // In-order fill and drain
        issue_a(4);
        check("iss4_can_issue", 64'(a_can_issue), 64'd0);
        for (int unsigned i = 0; i < 4; i++) resp_a(32'hA0 + i, 1'b1);
        check("fill_count", 64'(a_count), 64'd4);
        check("fill_full", 64'(a_full), 64'd1);
        check("fill_can_issue", 64'(a_can_issue), 64'd0);
        for (int unsigned i = 0; i < 4; i++) pop_a("drain_order");
        check("drain_empty", 64'(a_empty), 64'd1);

        // Clear with reads in flight
        issue_a(3);
        resp_a(32'h11, 1'b1);
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        sb_a.delete();
        check("clr_count", 64'(a_count), 64'd0);
        check("clr_discard", 64'(dut_a.discard), 64'd2);
        resp_a(32'hEE, 1'b0);
        resp_a(32'hEF, 1'b0);
        check("discard_count", 64'(a_count), 64'd0);
        check("discard_done", 64'(dut_a.discard), 64'd0);
        check("discard_outst", 64'(dut_a.outstanding), 64'd0);
        issue_a(1);
        resp_a(32'h22, 1'b1);
        check("post_clr_count", 64'(a_count), 64'd1);
        pop_a("post_clr_head");

        // Clear coinciding with a response and a new issue
        issue_a(1);
        step_a(1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
        check("clr_rsp_count", 64'(a_count), 64'd0);
        check("clr_iss_outst", 64'(dut_a.outstanding), 64'd1);
        check("clr_iss_discard", 64'(dut_a.discard), 64'd0);
        resp_a(32'h44, 1'b1);
        check("clr_iss_stored", 64'(a_count), 64'd1);
        pop_a("clr_iss_head");

        // Push and pop together while full
        issue_a(4);
        for (int unsigned i = 0; i < 4; i++) resp_a(32'hB0 + i, 1'b1);
        issue_a(1);
        begin
            logic [31:0] exp;
            exp = (sb_a.size() != 0) ? sb_a.pop_front() : 'x;
            check("full_pp_head", 64'(a_head), 64'(exp));
            sb_a.push_back(32'h55);
            step_a(1'b0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        end
        check("full_pp_count", 64'(a_count), 64'd4);
        check("full_pp_overflow", 64'(a_overflow), 64'd0);
        for (int unsigned i = 0; i < 4; i++) pop_a("full_pp_order");
        check("full_pp_empty", 64'(a_empty), 64'd1);

        // Sticky error flags
        resp_a(32'h99, 1'b0);
        check("unexp_flag", 64'(a_unexpected), 64'd1);
        check("unexp_count", 64'(a_count), 64'd0);
        issue_a(4);
        for (int unsigned i = 0; i < 4; i++) resp_a(32'hC0 + i, 1'b1);
        issue_a(1);
        resp_a(32'hDD, 1'b0);
        check("ovf_flag", 64'(a_overflow), 64'd1);
        check("ovf_count", 64'(a_count), 64'd4);
        pop_a("ovf_head_kept");
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        sb_a.delete();
        check("clr_keeps_flags", 64'({a_overflow, a_unexpected}), 64'b11);
        check("clr_flags_count", 64'(a_count), 64'd0);

        // Reset mid-transfer abandons in-flight state
        issue_a(2);
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst2_flags", 64'({a_overflow, a_unexpected}), 64'd0);
        check("rst2_outst", 64'(dut_a.outstanding), 64'd0);
        check("rst2_discard", 64'(dut_a.discard), 64'd0);
        check("rst2_can_issue", 64'(a_can_issue), 64'd1);
        check("rst2_empty", 64'(a_empty), 64'd1);

        // Streaming through the wide, deep instance
        begin
            int unsigned issued = 0, responded = 0, popped = 0, cycles = 0;
            while (popped < 20 && cycles < 200) begin
                logic [63:0] exp;
                b_issue = (issued < 20) && b_can_issue;
                b_valid = (responded < issued);
                b_data  = 64'hC0DE_0000_0000_0000 | 64'(responded);
                b_pop   = !b_empty;
                if (b_valid) sb_b.push_back(b_data);
                if (b_pop) begin
                    exp = (sb_b.size() != 0) ? sb_b.pop_front() : 'x;
                    check("stream_order", b_head, exp);
                    popped++;
                end
                if (b_issue) issued++;
                if (b_valid) responded++;
                cycles++;
                @(posedge clk); #1;
            end
            b_issue = 1'b0; b_valid = 1'b0; b_pop = 1'b0;
            check("stream_popped", 64'(popped), 64'd20);
            check("stream_overflow", 64'(b_overflow), 64'd0);
            check("stream_unexpected", 64'(b_unexpected), 64'd0);
            check("stream_empty", 64'(b_empty), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
